// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Codes shared between the highway/country-road light controller
//                and the country-road sensor.
//                - Light codes RED/YELLOW/GREEN (2'b11 is illegal).
//                - Sensor FSM state codes IDLE/REQUEST/SERVING/DRAIN.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    typedef logic [1:0] light_t;
    typedef logic [1:0] sensor_state_t;

    localparam light_t RED    = 2'b00;
    localparam light_t YELLOW = 2'b01;
    localparam light_t GREEN  = 2'b10;

    localparam sensor_state_t IDLE    = 2'b00;
    localparam sensor_state_t REQUEST = 2'b01;
    localparam sensor_state_t SERVING = 2'b10;
    localparam sensor_state_t DRAIN   = 2'b11;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/country_road_sensor_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : loop_debouncer
//  Description : Synchronises and debounces the raw inductive-loop level and
//                emits a one-cycle pulse when the accepted level rises.
//  Ports       : clk        - rising-edge clock
//                clear_n    - asynchronous active-low reset
//                loop_raw_i - raw, asynchronous, bouncy loop level
//                rise_o     - one-cycle pulse on accepted 0->1 transition
//  Revision    : 1.0  initial release
// ============================================================================
module loop_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic loop_raw_i,
    output logic rise_o
);

    localparam int            CW      = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q,  filt_d;
    logic          rise_q,  rise_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // The new level is accepted on the edge where the disagreement count
    // would reach DEBOUNCE_CYCLES; any agreement restarts the count.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise_d = filt_d & ~filt_q;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= loop_raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule : loop_debouncer
`default_nettype wire

// File: rtl/country_road_sensor.sv
`default_nettype none
// ============================================================================
//  Module      : country_road_sensor
//  Description : Country-road car-waiting request generator. Debounces the
//                loop detector, queues arriving vehicles, retires one vehicle
//                per PASS_CYCLES GREEN cycles and requests the right of way
//                while vehicles wait.
//  Ports       : clk       - rising-edge clock
//                clear_n   - asynchronous active-low reset
//                loop_raw  - raw loop detector level
//                cr_light  - country-road light (RED/YELLOW/GREEN)
//                X         - car-waiting request
//                car_count - queue depth
//                overflow  - sticky arrival-dropped flag
//  Revision    : 1.0  initial release
// ============================================================================
module country_road_sensor
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int PASS_CYCLES     = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             loop_raw,
    input  logic [1:0]       cr_light,
    output logic             X,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    localparam int               PW        = (PASS_CYCLES < 2) ? 1 : $clog2(PASS_CYCLES + 1);
    localparam logic [PW-1:0]    PASS_LAST = PW'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             arrive;
    logic             green;
    logic             red;
    logic             busy;
    logic             depart;
    logic [PW-1:0]    pass_q,  pass_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q,   ovf_d;
    sensor_state_t    state_q, state_d;

    loop_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk        (clk),
        .clear_n    (clear_n),
        .loop_raw_i (loop_raw),
        .rise_o     (arrive)
    );

    // The illegal code 2'b11 is neither GREEN nor RED.
    assign green  = (cr_light == GREEN);
    assign red    = (cr_light == RED);
    assign busy   = green && (count_q != '0);
    assign depart = busy && (pass_q == PASS_LAST);

    always_comb begin
        pass_d = (!busy || depart) ? '0 : pass_q + PW'(1);

        count_d = count_q;
        ovf_d   = ovf_q;
        if (arrive && !depart) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (depart && !arrive) begin
            // depart implies count_q != 0, so no underflow is possible
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = REQUEST;
            REQUEST: if (green)         state_d = SERVING;
            SERVING: if (count_q == '0) state_d = DRAIN;
            DRAIN:   if (red)           state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pass_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            pass_q  <= pass_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign X         = (state_q == REQUEST) || (state_q == SERVING);
    assign car_count = count_q;
    assign overflow  = ovf_q;

endmodule : country_road_sensor
`default_nettype wire

// File: tb/tb_country_road_sensor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_country_road_sensor
//  Description : Directed self-checking bench for country_road_sensor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_country_road_sensor;
    import traffic_pkg::*;

    logic       clk;
    logic       clear_n;
    logic       loop_raw;
    logic [1:0] cr_light;
    logic       x_o;
    logic [3:0] cnt_o;
    logic       ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    country_road_sensor #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4),
        .PASS_CYCLES     (2)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .loop_raw  (loop_raw),
        .cr_light  (cr_light),
        .X         (x_o),
        .car_count (cnt_o),
        .overflow  (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; returns 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clear_n  = 1'b0;
        loop_raw = 1'b0;
        cr_light = RED;
        repeat (2) tick();
        clear_n = 1'b1;
    endtask

    // One vehicle: held long enough to be accepted, released long enough
    // for the accepted level to return to 0.
    task automatic car();
        loop_raw = 1'b1;
        repeat (8) tick();
        loop_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        clear_n  = 1'b0;
        loop_raw = 1'b0;
        cr_light = RED;
        #3;
        check("rst_X",     {31'd0, x_o},   32'd0);
        check("rst_count", {28'd0, cnt_o}, 32'd0);
        check("rst_ovf",   {31'd0, ovf_o}, 32'd0);
        check("rst_state", {30'd0, dut.state_q}, {30'd0, IDLE});

        // ---- Arrival latency: edge 0 is the first edge seeing loop_raw=1
        do_reset();
        loop_raw = 1'b1;
        repeat (6) tick();                      // edges 0..5
        check("lat_count_e5", {28'd0, cnt_o}, 32'd0);
        tick();                                 // edge 6
        check("lat_count_e6", {28'd0, cnt_o}, 32'd1);
        check("lat_X_e6",     {31'd0, x_o},   32'd0);
        tick();                                 // edge 7
        check("lat_X_e7",     {31'd0, x_o},   32'd1);
        repeat (2) tick();
        loop_raw = 1'b0;
        repeat (12) tick();
        check("rel_count", {28'd0, cnt_o}, 32'd1);
        check("rel_X",     {31'd0, x_o},   32'd1);

        // ---- Bounce: high pulses of 1-3 cycles never get accepted
        clear_n = 1'b0;
        #2;
        check("midrst_count", {28'd0, cnt_o}, 32'd0);
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            loop_raw = 1'b1;
            repeat ((i % 3) + 1) tick();
            loop_raw = 1'b0;
            repeat (2) tick();
            check("bounce_count", {28'd0, cnt_o}, 32'd0);
            check("bounce_X",     {31'd0, x_o},   32'd0);
        end
        repeat (8) tick();
        check("bounce_end_count", {28'd0, cnt_o}, 32'd0);

        // ---- Queue 3 cars, then serve on GREEN
        do_reset();
        repeat (3) car();
        check("q3_count", {28'd0, cnt_o}, 32'd3);
        check("q3_X",     {31'd0, x_o},   32'd1);
        cr_light = GREEN;
        tick();                                 // SERVING, timer 1
        check("srv_count_t1", {28'd0, cnt_o}, 32'd3);
        tick();
        check("srv_count_t2", {28'd0, cnt_o}, 32'd2);
        tick();
        check("srv_count_t3", {28'd0, cnt_o}, 32'd2);
        tick();
        check("srv_count_t4", {28'd0, cnt_o}, 32'd1);
        repeat (2) tick();
        check("srv_count_t6", {28'd0, cnt_o}, 32'd0);
        check("srv_X_t6",     {31'd0, x_o},   32'd1);
        tick();
        check("srv_X_t7",     {31'd0, x_o},   32'd0);
        check("srv_state_t7", {30'd0, dut.state_q}, {30'd0, DRAIN});
        cr_light = YELLOW;
        tick();
        check("yel_state", {30'd0, dut.state_q}, {30'd0, DRAIN});
        cr_light = RED;
        tick();
        check("red_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        check("red_X",     {31'd0, x_o},   32'd0);

        // ---- Arrival and departure on the same edge
        do_reset();
        repeat (4) car();
        repeat (2) tick();
        check("sim_start_count", {28'd0, cnt_o}, 32'd4);
        loop_raw = 1'b1;
        tick();                                 // edge 0
        cr_light = GREEN;
        tick();                                 // edge 1: timer 1
        tick();                                 // edge 2: depart
        check("sim_e2", {28'd0, cnt_o}, 32'd3);
        repeat (2) tick();                      // edge 4: depart
        check("sim_e4", {28'd0, cnt_o}, 32'd2);
        repeat (2) tick();                      // edge 6: depart + arrive
        check("sim_e6", {28'd0, cnt_o}, 32'd2);
        loop_raw = 1'b0;
        tick();
        check("sim_e7", {28'd0, cnt_o}, 32'd2);
        tick();                                 // edge 8: depart
        check("sim_e8", {28'd0, cnt_o}, 32'd1);
        repeat (2) tick();                      // edge 10: depart
        check("sim_e10", {28'd0, cnt_o}, 32'd0);
        tick();
        check("sim_drain", {30'd0, dut.state_q}, {30'd0, DRAIN});

        // ---- Arrival during DRAIN
        cr_light = YELLOW;
        car();
        check("drain_count", {28'd0, cnt_o}, 32'd1);
        check("drain_X",     {31'd0, x_o},   32'd0);
        cr_light = RED;
        tick();
        check("drain_idle",  {30'd0, dut.state_q}, {30'd0, IDLE});
        check("drain_idle_X", {31'd0, x_o}, 32'd0);
        tick();
        check("drain_rereq_X", {31'd0, x_o}, 32'd1);

        // ---- Saturation, illegal light code, sticky overflow
        do_reset();
        repeat (15) car();
        check("sat15_ovf", {31'd0, ovf_o}, 32'd0);
        car();
        check("sat_count", {28'd0, cnt_o}, 32'd15);
        check("sat_ovf",   {31'd0, ovf_o}, 32'd1);
        cr_light = GREEN;
        repeat (2) tick();
        check("sat_dep1", {28'd0, cnt_o}, 32'd14);
        tick();                                 // timer 1
        cr_light = 2'b11;
        repeat (4) tick();
        check("ill_count", {28'd0, cnt_o}, 32'd14);
        check("ill_state", {30'd0, dut.state_q}, {30'd0, SERVING});
        cr_light = GREEN;
        tick();                                 // timer restarted from 0
        check("ill_restart", {28'd0, cnt_o}, 32'd14);
        repeat (26) tick();
        check("sat_cnt1", {28'd0, cnt_o}, 32'd1);
        tick();
        check("sat_cnt0", {28'd0, cnt_o}, 32'd0);
        check("sat_ovf_sticky", {31'd0, ovf_o}, 32'd1);
        clear_n = 1'b0;
        #2;
        check("clr_ovf",   {31'd0, ovf_o}, 32'd0);
        check("clr_count", {28'd0, cnt_o}, 32'd0);
        tick();
        clear_n = 1'b1;

        // ---- Asynchronous reset between edges during SERVING
        do_reset();
        repeat (2) car();
        cr_light = GREEN;
        tick();
        check("as_X_serving", {31'd0, x_o}, 32'd1);
        tick();
        check("as_count", {28'd0, cnt_o}, 32'd1);
        #2;
        clear_n = 1'b0;
        #1;
        check("as_X",     {31'd0, x_o},   32'd0);
        check("as_count0", {28'd0, cnt_o}, 32'd0);
        check("as_ovf",   {31'd0, ovf_o}, 32'd0);
        check("as_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        tick();
        clear_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_country_road_sensor
`default_nettype wire

// File: doc/country_road_sensor.md
# country_road_sensor

Conditions the country-road inductive-loop detector and produces the car-waiting request `X` consumed by the highway/country-road traffic light controller. It synchronises and debounces the raw loop signal, counts queued vehicles, and retires them while the country road shows GREEN. `X` stays high until the queue is empty, then drops so the controller can return the right of way to the highway.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a new loop level must hold before it is accepted (≥1).
- `CNT_W`, 4: width of the vehicle queue counter.
- `PASS_CYCLES`, 2: consecutive GREEN cycles that retire one queued vehicle (≥1).
- `clk` in 1: the only clock; all flops are rising-edge.
- `clear_n` in 1: reset, asynchronous, active-low.
- `loop_raw` in 1: raw loop detector level, asynchronous, bouncy; 1 = metal over the loop.
- `cr_light` in 2: country-road light from the controller: RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 is illegal.
- `X` out 1: car-waiting request to the controller.
- `car_count` out CNT_W: current queue depth.
- `overflow` out 1: sticky flag; set when an arrival is dropped at saturation.

## Operation
- Sync: `loop_raw` passes through a 2-flop synchroniser, producing `s2`.
- Debounce: `filt` holds the accepted level. The counter increments each cycle `s2 != filt` and clears whenever `s2 == filt`. `filt` takes `s2` on the edge where the counter would reach `DEBOUNCE_CYCLES`, and the counter clears on that edge.
- Arrival: one-cycle pulse on the `filt` 0→1 transition. A falling `filt` has no effect.
- Departure: the pass timer counts while `cr_light==GREEN && car_count!=0`. At `PASS_CYCLES` it emits a departure pulse and restarts. It clears whenever either condition is false.
- Counter update:
  - arrival only: +1, saturating at 2^CNT_W−1; an arrival at max sets `overflow`.
  - departure only: −1, never below 0.
  - both in the same cycle: unchanged.
- FSM (registered; `X` decoded from the state register, high in REQUEST and SERVING):
  - IDLE → REQUEST when `car_count!=0`.
  - REQUEST → SERVING when `cr_light==GREEN`.
  - SERVING → DRAIN when `car_count==0`.
  - DRAIN → IDLE when `cr_light==RED`.
  - Arrivals during DRAIN are counted. IDLE then re-requests on the next edge.
- `cr_light==2'b11` is treated as not GREEN and not RED. The FSM holds in SERVING/DRAIN, and the pass timer clears.

## Timing
- Reset (async assert, sync-free): sync flops=0, `filt`=0, debounce/pass counters=0, state=IDLE, `X`=0, `car_count`=0, `overflow`=0. A reset mid-operation discards the queue.
- Arrival latency, with edge 0 the first edge sampling `loop_raw`=1 held stable:
  - `s2`=1 after edge 1.
  - `filt`=1 after edge `DEBOUNCE_CYCLES`+1.
  - `car_count` increments at edge `DEBOUNCE_CYCLES`+2.
  - `X` rises at edge `DEBOUNCE_CYCLES`+3 (edge 7 with defaults).
- Pulses on `s2` shorter than `DEBOUNCE_CYCLES` cycles never change `filt`.
- A departure takes `PASS_CYCLES` GREEN cycles from timer start. `X` falls one edge after `car_count` reaches 0.
- `car_count` and `overflow` are registered outputs. `X` changes only on the edges where state changes.

## Structure
- Shared package `traffic_pkg`: light codes RED/YELLOW/GREEN (shared with the controller) and this block's state codes IDLE/REQUEST/SERVING/DRAIN.
- Sub-module `loop_debouncer` (params `DEBOUNCE_CYCLES`): contains the synchroniser, debounce counter, `filt`, and rising-edge pulse. The top level holds the queue counter, pass timer, and FSM.

## Test plan
- Reset, then `loop_raw` high for 10 cycles with `cr_light`=RED: `car_count`=1 at edge 6, `X`=1 at edge 7. After release, `car_count` stays 1 and `X` stays 1.
- Bounce: `loop_raw` toggles with high pulses of 1–3 cycles for 40 cycles: `filt` never rises, `car_count`=0, `X`=0.
- Queue 3 cars, then hold `cr_light`=GREEN: `car_count` steps 3→2→1→0 every 2 cycles, and `X` falls one edge after reaching 0. Then `cr_light`=YELLOW→RED returns the FSM to IDLE.
- Simultaneous events: an arrival pulse on the same edge as a departure with `car_count`=2 leaves `car_count`=2. An arrival during DRAIN gives `X`=1 again one edge after RED.
- Saturation: 16 arrivals with `CNT_W`=4: `car_count`=15, `overflow`=1. The flag stays 1 after 15 departures, and a subsequent `clear_n` pulse clears everything.
- Asynchronous reset asserted mid-SERVING (between clock edges): all outputs go to 0/IDLE immediately, and `X`=0 before the next edge.
